// File: rtl/mips32_mem_responder_if.sv
// Fetch and data request/response channels between the MIPS32 core and its memory responder.
// Every channel is valid/ready: a beat transfers on a posedge where valid && ready are both 1.
interface mips32_mem_responder_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic        if_rsp_ready;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;

    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic        d_rsp_ready;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;

    modport slave (
        input  if_req_valid, if_req_addr, if_rsp_ready,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
    );

    modport master (
        output if_req_valid, if_req_addr, if_rsp_ready,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
    );
endinterface

// File: rtl/mips32_mem_responder.sv
// Word-addressed single-port RAM shared by the MIPS32 fetch and data ports.
// One access per cycle; a contested-grant streak keeps the fetch port from starving.
module mips32_mem_responder #(
    parameter int    DEPTH      = 1024,
    parameter string INIT_FILE  = "",
    parameter int    STARVE_MAX = 2
) (
    input logic                   clk,
    input logic                   rst,
    mips32_mem_responder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STREAK_TOP = SW'(STARVE_MAX);
    localparam logic [31:0]   DEPTH_W    = 32'(DEPTH);

    logic [31:0] mem [DEPTH];

    logic          if_free, d_free, if_elig, d_elig, if_grant, d_grant;
    logic [31:0]   acc_addr;
    logic [AW-1:0] acc_idx;
    logic          acc_ok;
    logic [31:0]   rd_word;
    logic          wr_en;

    logic          if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0]   if_rsp_data_q, if_rsp_data_d;
    logic          if_rsp_err_q, if_rsp_err_d;
    logic          d_rsp_valid_q, d_rsp_valid_d;
    logic [31:0]   d_rsp_data_q, d_rsp_data_d;
    logic          d_rsp_err_q, d_rsp_err_d;
    logic [SW-1:0] streak_q, streak_d;

    // Arbitration and the single shared RAM access port. Nothing is eligible during reset,
    // so request fields of unaccepted requests never reach state.
    always_comb begin
        if_free  = !if_rsp_valid_q || bus.if_rsp_ready;
        d_free   = !d_rsp_valid_q || bus.d_rsp_ready;
        if_elig  = !rst && bus.if_req_valid && if_free;
        d_elig   = !rst && bus.d_req_valid && d_free;
        d_grant  = d_elig && !(if_elig && (streak_q == STREAK_TOP));
        if_grant = if_elig && !d_grant;
        acc_addr = if_grant ? bus.if_req_addr : bus.d_req_addr;
        acc_ok   = (acc_addr < DEPTH_W);
        acc_idx  = acc_addr[AW-1:0];
        rd_word  = mem[acc_idx];
        wr_en    = d_grant && bus.d_req_we && acc_ok;
    end

    always_comb begin
        if_rsp_valid_d = if_rsp_valid_q && !bus.if_rsp_ready;
        if_rsp_data_d  = if_rsp_data_q;
        if_rsp_err_d   = if_rsp_err_q;
        d_rsp_valid_d  = d_rsp_valid_q && !bus.d_rsp_ready;
        d_rsp_data_d   = d_rsp_data_q;
        d_rsp_err_d    = d_rsp_err_q;
        streak_d       = streak_q;

        if (if_grant) begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = acc_ok ? rd_word : 32'h0;
            if_rsp_err_d   = !acc_ok;
            streak_d       = '0;
        end

        if (d_grant) begin
            d_rsp_valid_d = 1'b1;
            d_rsp_data_d  = (acc_ok && !bus.d_req_we) ? rd_word : 32'h0;
            d_rsp_err_d   = !acc_ok;
            // The streak only counts data wins that actually held back a fetch.
            if (if_elig && (streak_q != STREAK_TOP)) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= 32'h0;
            if_rsp_err_q   <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_data_q   <= 32'h0;
            d_rsp_err_q    <= 1'b0;
            streak_q       <= '0;
        end else begin
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            if_rsp_err_q   <= if_rsp_err_d;
            d_rsp_valid_q  <= d_rsp_valid_d;
            d_rsp_data_q   <= d_rsp_data_d;
            d_rsp_err_q    <= d_rsp_err_d;
            streak_q       <= streak_d;
        end
    end

    // RAM contents deliberately survive reset so a loaded program keeps running.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[acc_idx] <= bus.d_req_wdata;
        end
    end

    assign bus.if_req_ready = if_grant;
    assign bus.if_rsp_valid = if_rsp_valid_q;
    assign bus.if_rsp_data  = if_rsp_data_q;
    assign bus.if_rsp_err   = if_rsp_err_q;
    assign bus.d_req_ready  = d_grant;
    assign bus.d_rsp_valid  = d_rsp_valid_q;
    assign bus.d_rsp_data   = d_rsp_data_q;
    assign bus.d_rsp_err    = d_rsp_err_q;
endmodule

// File: tb/tb_mips32_mem_responder.sv
// Bench for mips32_mem_responder: table vectors, directed corner sequences and random traffic,
// all checked every cycle against a queue-based transaction model.
module tb_mips32_mem_responder;
    localparam int DEPTH  = 1024;
    localparam int STARVE = 2;

    logic clk = 1'b0;
    logic rst;

    mips32_mem_responder_if bus();

    mips32_mem_responder #(
        .DEPTH(DEPTH),
        .INIT_FILE(""),
        .STARVE_MAX(STARVE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Pending responses per port as {err, data}; the head is what the port must be showing.
    logic [32:0] exp_if_q[$];
    logic [32:0] exp_d_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          m_streak = 0;

    logic        obs_if_rdy, obs_d_rdy, obs_if_rv, obs_d_rv, obs_if_err, obs_d_err;
    logic [31:0] obs_if_data, obs_d_data;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = 32'h0;
        bus.if_rsp_ready = 1'b1;
        bus.d_req_valid  = 1'b0;
        bus.d_req_we     = 1'b0;
        bus.d_req_addr   = 32'h0;
        bus.d_req_wdata  = 32'h0;
        bus.d_rsp_ready  = 1'b1;
    endtask

    task automatic set_if(input logic v, input logic [31:0] a, input logic rr);
        bus.if_req_valid = v;
        bus.if_req_addr  = a;
        bus.if_rsp_ready = rr;
    endtask

    task automatic set_d(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic rr);
        bus.d_req_valid = v;
        bus.d_req_we    = we;
        bus.d_req_addr  = a;
        bus.d_req_wdata = wd;
        bus.d_rsp_ready = rr;
    endtask

    function automatic logic [32:0] model_read(input logic [31:0] a);
        logic [9:0] idx;
        idx = a[9:0];
        if (a >= DEPTH) return {1'b1, 32'h0};
        return {1'b0, ref_mem[idx]};
    endfunction

    // One clock cycle: called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        logic        if_free, d_free, if_el, d_el, if_g, d_g, fetch_wins;
        logic        c_rst, c_if_rr, c_d_rr, c_we;
        logic [31:0] c_if_a, c_d_a, c_wd;
        logic [9:0]  widx;
        #2;
        c_rst   = rst;
        c_if_rr = bus.if_rsp_ready;
        c_d_rr  = bus.d_rsp_ready;
        c_if_a  = bus.if_req_addr;
        c_d_a   = bus.d_req_addr;
        c_we    = bus.d_req_we;
        c_wd    = bus.d_req_wdata;

        if_free = (exp_if_q.size() == 0) || c_if_rr;
        d_free  = (exp_d_q.size() == 0) || c_d_rr;
        if_el   = !c_rst && bus.if_req_valid && if_free;
        d_el    = !c_rst && bus.d_req_valid && d_free;
        if (if_el && d_el) begin
            fetch_wins = (m_streak >= STARVE);
            if_g = fetch_wins;
            d_g  = !fetch_wins;
        end else begin
            if_g = if_el;
            d_g  = d_el;
        end

        obs_if_rdy  = bus.if_req_ready;
        obs_d_rdy   = bus.d_req_ready;
        obs_if_rv   = bus.if_rsp_valid;
        obs_d_rv    = bus.d_rsp_valid;
        obs_if_data = bus.if_rsp_data;
        obs_d_data  = bus.d_rsp_data;
        obs_if_err  = bus.if_rsp_err;
        obs_d_err   = bus.d_rsp_err;

        chk1("if_req_ready", obs_if_rdy, if_g);
        chk1("d_req_ready", obs_d_rdy, d_g);
        chk1("if_rsp_valid", obs_if_rv, exp_if_q.size() != 0);
        chk1("d_rsp_valid", obs_d_rv, exp_d_q.size() != 0);
        if (exp_if_q.size() != 0) begin
            chk32("if_rsp_data", obs_if_data, exp_if_q[0][31:0]);
            chk1("if_rsp_err", obs_if_err, exp_if_q[0][32]);
        end
        if (exp_d_q.size() != 0) begin
            chk32("d_rsp_data", obs_d_data, exp_d_q[0][31:0]);
            chk1("d_rsp_err", obs_d_err, exp_d_q[0][32]);
        end

        @(posedge clk);
        if (c_rst) begin
            exp_if_q.delete();
            exp_d_q.delete();
            m_streak = 0;
        end else begin
            if (exp_if_q.size() != 0 && c_if_rr) void'(exp_if_q.pop_front());
            if (exp_d_q.size() != 0 && c_d_rr) void'(exp_d_q.pop_front());
            if (if_g) begin
                exp_if_q.push_back(model_read(c_if_a));
                m_streak = 0;
            end
            if (d_g) begin
                if (c_we) begin
                    widx = c_d_a[9:0];
                    if (c_d_a < DEPTH) ref_mem[widx] = c_wd;
                    exp_d_q.push_back({(c_d_a >= DEPTH), 32'h0});
                end else begin
                    exp_d_q.push_back(model_read(c_d_a));
                end
                if (if_el && m_streak < STARVE) m_streak++;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'(DEPTH) + $urandom_range(0, 32'hFFFF);
        if (r == 1) return 32'(DEPTH - 1);
        return $urandom_range(0, 31);
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 32'd3,        32'h33333333, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'd3,        32'h0,        32'h33333333, 1'b0};
        vecs[2]  = '{1'b0, 32'd1024,     32'h0,        32'h0,        1'b1};
        vecs[3]  = '{1'b1, 32'hFFFF0003, 32'h12345678, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 32'd3,        32'h0,        32'h33333333, 1'b0};
        vecs[5]  = '{1'b1, 32'd1023,     32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'd1023,     32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'd1024,     32'h0BADF00D, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'd1023,     32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b0, 32'd0,        32'h0,        32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'd31,       32'h0,        32'h1F,       1'b0};

        // Reset, with requests offered during reset that must not be accepted.
        rst = 1'b1;
        set_idle();
        repeat (2) @(negedge clk);
        set_if(1'b1, 32'd0, 1'b1);
        set_d(1'b1, 1'b1, 32'd0, 32'hFFFFFFFF, 1'b1);
        tick();
        rst = 1'b0;
        set_idle();
        tick();
        chk1("reset if_rsp_valid", obs_if_rv, 1'b0);
        chk1("reset d_rsp_valid", obs_d_rv, 1'b0);
        chk32("reset if_rsp_data", obs_if_data, 32'h0);
        chk32("reset d_rsp_data", obs_d_data, 32'h0);
        chk1("reset if_rsp_err", obs_if_err, 1'b0);
        chk1("reset d_rsp_err", obs_d_err, 1'b0);

        // Preload words 0..31 with their own address.
        for (int i = 0; i < 32; i++) begin
            set_d(1'b1, 1'b1, 32'(i), 32'(i), 1'b1);
            tick();
        end
        set_idle();
        tick();

        // Back-to-back fetch stream 0..15.
        for (int k = 0; k < 16; k++) begin
            set_if(1'b1, 32'(k), 1'b1);
            tick();
            chk1("stream if_req_ready", obs_if_rdy, 1'b1);
            if (k > 0) begin
                chk1("stream if_rsp_valid", obs_if_rv, 1'b1);
                chk32("stream if_rsp_data", obs_if_data, 32'(k - 1));
            end
        end
        set_idle();
        tick();
        chk32("stream last data", obs_if_data, 32'd15);

        // Table of single data-port transactions, including range boundaries.
        for (int v = 0; v < 12; v++) begin
            set_d(1'b1, vecs[v].we, vecs[v].addr, vecs[v].wdata, 1'b1);
            tick();
            chk1("vec accept", obs_d_rdy, 1'b1);
            set_idle();
            tick();
            chk1("vec rsp_valid", obs_d_rv, 1'b1);
            chk32("vec rsp_data", obs_d_data, vecs[v].exp_data);
            chk1("vec rsp_err", obs_d_err, vecs[v].exp_err);
        end

        // Store at N is visible to a fetch accepted at N+1.
        set_d(1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 1'b1);
        tick();
        set_idle();
        set_if(1'b1, 32'd5, 1'b1);
        tick();
        chk32("smc store rsp_data", obs_d_data, 32'h0);
        chk1("smc store rsp_err", obs_d_err, 1'b0);
        set_idle();
        tick();
        chk1("smc fetch valid", obs_if_rv, 1'b1);
        chk32("smc fetch data", obs_if_data, 32'hDEADBEEF);

        // Continuous contention: data, data, fetch, repeating.
        for (int k = 0; k < 9; k++) begin
            set_if(1'b1, 32'd0, 1'b1);
            set_d(1'b1, 1'b0, 32'd1, 32'h0, 1'b1);
            tick();
            chk1("contend d grant", obs_d_rdy, (k % 3) != 2);
            chk1("contend if grant", obs_if_rdy, (k % 3) == 2);
        end
        set_idle();
        tick();

        // Fetch response held under backpressure while the data port keeps streaming.
        set_if(1'b1, 32'd7, 1'b1);
        tick();
        for (int j = 0; j < 4; j++) begin
            set_if(1'b1, 32'd8, 1'b0);
            set_d(1'b1, 1'b0, 32'(j + 10), 32'h0, 1'b1);
            tick();
            chk1("hold if_rsp_valid", obs_if_rv, 1'b1);
            chk32("hold if_rsp_data", obs_if_data, 32'd7);
            chk1("hold if_req_ready", obs_if_rdy, 1'b0);
            chk1("hold d_req_ready", obs_d_rdy, 1'b1);
        end
        set_idle();
        set_if(1'b1, 32'd8, 1'b1);
        tick();
        chk1("consume+accept ready", obs_if_rdy, 1'b1);
        chk32("consume+accept old data", obs_if_data, 32'd7);
        set_idle();
        tick();
        chk32("consume+accept new data", obs_if_data, 32'd8);

        // Reset with a response pending and the streak at its limit.
        set_if(1'b1, 32'd9, 1'b1);
        set_d(1'b1, 1'b0, 32'd10, 32'h0, 1'b1);
        tick();
        set_if(1'b1, 32'd9, 1'b0);
        tick();
        rst = 1'b1;
        set_d(1'b1, 1'b0, 32'd10, 32'h0, 1'b0);
        tick();
        chk1("mid-reset if_req_ready", obs_if_rdy, 1'b0);
        chk1("mid-reset d_req_ready", obs_d_rdy, 1'b0);
        rst = 1'b0;
        set_idle();
        tick();
        chk1("post-reset if_rsp_valid", obs_if_rv, 1'b0);
        chk1("post-reset d_rsp_valid", obs_d_rv, 1'b0);
        for (int k = 0; k < 3; k++) begin
            set_if(1'b1, 32'd0, 1'b1);
            set_d(1'b1, 1'b0, 32'd1, 32'h0, 1'b1);
            tick();
            chk1("post-reset streak d grant", obs_d_rdy, k != 2);
        end
        set_idle();
        set_d(1'b1, 1'b0, 32'd5, 32'h0, 1'b1);
        tick();
        set_idle();
        tick();
        chk32("ram survives reset", obs_d_data, 32'hDEADBEEF);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_if($urandom_range(0, 1) == 1, rand_addr(), $urandom_range(0, 3) != 0);
            set_d($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(),
                  $urandom(), $urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        set_idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
